fp2_mul_arbiter: RTL and testbench
==================================

Name: fp2_mul_arbiter

Overview:
- Round-robin scheduler that shares one fp2_mont_mul instance and its input/result memories between NUM_REQ requesters (e.g. APB front-end plus hardware isogeny sequencers).
- Grants exclusive ownership, then sequences the job: operand load window, one-cycle mult_rst, one-cycle mult_start, wait for done, result drain window.
- Exports the owner index so the top level muxes memory write/read ports; this block itself carries no operand data.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REQ_LOG, `CLOG2(NUM_REQ) (min 1), width of owner index.
- TIMEOUT_CYCLES, 4096, WAIT-state watchdog limit (used only with FP2_ARB_TIMEOUT_EN).
- CNT_W, 16, width of completed-job counter.

Ports:
- io_mainClk  in  1  clock
- io_systemReset  in  1  asynchronous active-high reset
- req  in  NUM_REQ  requester i wants the multiplier; level, held until release
- load_done  in  NUM_REQ  one-cycle pulse: owner finished writing a_0/a_1/b_0/b_1
- release  in  NUM_REQ  one-cycle pulse: owner finished reading results
- gnt  out  NUM_REQ  one-hot ownership, registered
- owner_idx  out  REQ_LOG  binary index of current owner, valid when |gnt
- job_done  out  NUM_REQ  one-cycle pulse to owner when results are valid
- job_err  out  NUM_REQ  one-cycle pulse on watchdog expiry (0 without macro)
- mult_rst  out  1  to fp2_mont_mul rst
- mult_start  out  1  to fp2_mont_mul start
- mult_done  in  1  from fp2_mont_mul done
- mult_busy  in  1  from fp2_mont_mul busy
- arb_busy  out  1  high in every state except IDLE
- jobs_completed  out  CNT_W  count of job_done pulses, wraps

Behaviour:
- Reset (async): state IDLE; gnt=0, owner_idx=0, job_done=0, job_err=0, mult_rst=0, mult_start=0, arb_busy=0, jobs_completed=0, last_owner=NUM_REQ-1.
- States: IDLE, LOAD, RST, START, WAIT, DRAIN.
- IDLE: if any req, select the first requester with req set, scanning from last_owner+1 modulo NUM_REQ. Register gnt/owner_idx and go to LOAD. Minimum one IDLE cycle between jobs.
- LOAD: on load_done[owner] go to RST. If req[owner] drops first, abort: gnt=0, last_owner=owner, go to IDLE; no multiplier activity. load_done/release from non-owners are ignored.
- RST: mult_rst=1 for exactly 1 cycle, then START.
- START: mult_start=1 for exactly 1 cycle; never in the same cycle as mult_rst. Go to WAIT.
- WAIT: on mult_done, job_done[owner]=1 for 1 cycle, jobs_completed+1, go to DRAIN. A mult_done seen in any other state is ignored.
- DRAIN: gnt held. On release[owner]: gnt=0, last_owner=owner, go to IDLE. req[owner] dropping in DRAIN is treated as release.
- Latency: load_done to mult_start high = 2 cycles. req (multiplier idle) to gnt = 1 cycle.
- mult_busy is for consistency checking only: mult_busy=0 for more than 2 cycles after START while still in WAIT is a protocol error; simulation assertion only.
- Simultaneous events:
  - load_done and req drop in the same cycle: abort wins.
  - New requests while not IDLE are held pending, not queued further.
- Reset mid-job: all outputs return to reset values immediately. The requester must re-request.

Optional Feature:
- FP2_ARB_TIMEOUT_EN defined: a 32-bit counter is cleared on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without mult_done:
  - job_err[owner]=1 and mult_rst=1 for 1 cycle
  - gnt=0, last_owner=owner, go to IDLE
  - jobs_completed unchanged
- Undefined: no counter is built, job_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package fp2_arb_pkg holds the state encoding enum (IDLE=0 .. DRAIN=5) and the default TIMEOUT_CYCLES constant.
- One sub-module, rr_pick: combinational round-robin one-hot/index selector (req, last_owner -> gnt_next, idx_next), reusable by other shared-resource arbiters.

Test Plan:
- Single requester: req[0]=1 -> gnt=01 next cycle; load_done[0] -> mult_rst 1 cycle, then mult_start 1 cycle; mult_done -> job_done[0] pulse, jobs_completed=1; release[0] -> gnt=00, IDLE.
- Fairness: req=11 held, 4 jobs back-to-back -> gnt sequence 01,10,01,10; no two consecutive grants to the same requester.
- Abort: req[1] drops in LOAD -> gnt=00, no mult_rst/mult_start pulses, next grant goes to requester 0.
- Stray signals: mult_done in DRAIN and release[1] while requester 0 owns -> no state change, jobs_completed unchanged.
- Reset mid-WAIT: io_systemReset asserted -> gnt=0, arb_busy=0, jobs_completed=0 same cycle; after release, req[0] -> normal job completes.
- With FP2_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, mult_done never asserted -> job_err[owner] and mult_rst pulse on the 16th WAIT cycle, return to IDLE, jobs_completed=0.

Source files
------------

// File: rtl/fp2_arb_pkg.sv
// Shared definitions for the fp2 multiplier arbiter: state encoding and default watchdog limit.
package fp2_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RST   = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from last_owner+1 (mod N).
module rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned L = 1
) (
    input  logic [N-1:0] req,
    input  logic [L-1:0] last_owner,
    output logic [N-1:0] gnt_next,
    output logic [L-1:0] idx_next
);

    logic found_c;

    always_comb begin
        gnt_next = '0;
        idx_next = '0;
        found_c  = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            int unsigned cand;
            cand = 32'(last_owner) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found_c && req[L'(cand)]) begin
                gnt_next = N'(1) << cand;
                idx_next = L'(cand);
                found_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp2_mul_arbiter.sv
// Round-robin owner arbitration and job sequencing for a shared fp2_mont_mul.
// Build option: define FP2_ARB_TIMEOUT_EN to add the WAIT-state watchdog.
module fp2_mul_arbiter
    import fp2_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned REQ_LOG        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               io_mainClk,
    input  logic               io_systemReset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] load_done,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [REQ_LOG-1:0] owner_idx,
    output logic [NUM_REQ-1:0] job_done,
    output logic [NUM_REQ-1:0] job_err,
    output logic               mult_rst,
    output logic               mult_start,
    input  logic               mult_done,
    input  logic               mult_busy,
    output logic               arb_busy,
    output logic [CNT_W-1:0]   jobs_completed
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [REQ_LOG-1:0] owner_q, owner_d;
    logic [REQ_LOG-1:0] last_q, last_d;
    logic [NUM_REQ-1:0] job_done_q, job_done_d;
    logic [NUM_REQ-1:0] job_err_q, job_err_d;
    logic               mult_rst_q, mult_rst_d;
    logic               mult_start_q, mult_start_d;
    logic               arb_busy_q, arb_busy_d;
    logic [CNT_W-1:0]   jobs_q, jobs_d;
    logic [1:0]         busy_lo_q, busy_lo_d;

    logic [NUM_REQ-1:0] pick_gnt_c;
    logic [REQ_LOG-1:0] pick_idx_c;
    logic [NUM_REQ-1:0] owner_oh_c;
    logic               timeout_c;

    rr_pick #(
        .N (NUM_REQ),
        .L (REQ_LOG)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .gnt_next   (pick_gnt_c),
        .idx_next   (pick_idx_c)
    );

    assign owner_oh_c = NUM_REQ'(1) << owner_q;

`ifdef FP2_ARB_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;

    // Cleared whenever outside WAIT, so each WAIT entry starts from zero.
    always_comb begin
        to_cnt_d = 32'd0;
        if (state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            to_cnt_q <= 32'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_c = (state_q == ST_WAIT) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_c;
    assign unused_timeout_c = |32'(TIMEOUT_CYCLES);
    assign timeout_c        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        job_done_d   = '0;
        job_err_d    = '0;
        mult_rst_d   = 1'b0;
        mult_start_d = 1'b0;
        jobs_d       = jobs_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt_c;
                    owner_d = pick_idx_c;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Abort takes priority over a same-cycle load_done.
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else if (load_done[owner_q]) begin
                    mult_rst_d = 1'b1;
                    state_d    = ST_RST;
                end
            end
            ST_RST: begin
                mult_start_d = 1'b1;
                state_d      = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done) begin
                    job_done_d = owner_oh_c;
                    jobs_d     = jobs_q + CNT_W'(1);
                    state_d    = ST_DRAIN;
                end else if (timeout_c) begin
                    job_err_d  = owner_oh_c;
                    mult_rst_d = 1'b1;
                    gnt_d      = '0;
                    last_d     = owner_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (rel[owner_q] || !req[owner_q]) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        arb_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_q       <= REQ_LOG'(NUM_REQ - 1);
            job_done_q   <= '0;
            job_err_q    <= '0;
            mult_rst_q   <= 1'b0;
            mult_start_q <= 1'b0;
            arb_busy_q   <= 1'b0;
            jobs_q       <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            job_done_q   <= job_done_d;
            job_err_q    <= job_err_d;
            mult_rst_q   <= mult_rst_d;
            mult_start_q <= mult_start_d;
            arb_busy_q   <= arb_busy_d;
            jobs_q       <= jobs_d;
        end
    end

    // Consecutive WAIT cycles with the multiplier reporting idle.
    always_comb begin
        busy_lo_d = 2'd0;
        if (state_q == ST_WAIT && !mult_busy) begin
            busy_lo_d = (busy_lo_q == 2'd3) ? 2'd3 : busy_lo_q + 2'd1;
        end
    end

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            busy_lo_q <= 2'd0;
        end else begin
            busy_lo_q <= busy_lo_d;
        end
    end

    a_busy_consistent: assert property (@(posedge io_mainClk) disable iff (io_systemReset)
        !(state_q == ST_WAIT && !mult_busy && !mult_done && busy_lo_q >= 2'd2));

    a_rst_start_exclusive: assert property (@(posedge io_mainClk) disable iff (io_systemReset)
        !(mult_rst_q && mult_start_q));

    assign gnt            = gnt_q;
    assign owner_idx      = owner_q;
    assign job_done       = job_done_q;
    assign job_err        = job_err_q;
    assign mult_rst       = mult_rst_q;
    assign mult_start     = mult_start_q;
    assign arb_busy       = arb_busy_q;
    assign jobs_completed = jobs_q;

endmodule

// File: tb/tb_fp2_mul_arbiter.sv
// Directed bench for fp2_mul_arbiter: grant, sequencing, fairness, abort, stray inputs, reset, watchdog.
module tb_fp2_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  load_done;
    logic [1:0]  rel;
    logic [1:0]  gnt;
    logic [0:0]  owner_idx;
    logic [1:0]  job_done;
    logic [1:0]  job_err;
    logic        mult_rst;
    logic        mult_start;
    logic        mult_done;
    logic        mult_busy;
    logic        arb_busy;
    logic [15:0] jobs_completed;

    int checks   = 0;
    int failures = 0;
    int exp_jobs = 0;

    fp2_mul_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .io_mainClk     (clk),
        .io_systemReset (rst),
        .req            (req),
        .load_done      (load_done),
        .rel            (rel),
        .gnt            (gnt),
        .owner_idx      (owner_idx),
        .job_done       (job_done),
        .job_err        (job_err),
        .mult_rst       (mult_rst),
        .mult_start     (mult_start),
        .mult_done      (mult_done),
        .mult_busy      (mult_busy),
        .arb_busy       (arb_busy),
        .jobs_completed (jobs_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full job for the requester whose one-hot grant is g; req must already be set.
    task automatic run_job(input logic [1:0] g);
        step();
        chk("job_gnt", 32'(gnt), 32'(g));
        chk("job_owner", 32'(owner_idx), (g == 2'b10) ? 32'd1 : 32'd0);
        load_done = g;
        step();
        load_done = 2'b00;
        chk("job_mult_rst", 32'(mult_rst), 32'd1);
        chk("job_no_start_in_rst", 32'(mult_start), 32'd0);
        step();
        chk("job_mult_start", 32'(mult_start), 32'd1);
        chk("job_rst_dropped", 32'(mult_rst), 32'd0);
        mult_busy = 1'b1;
        step();
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        mult_busy = 1'b0;
        exp_jobs++;
        chk("job_done", 32'(job_done), 32'(g));
        chk("job_count", 32'(jobs_completed), 32'(exp_jobs));
        rel = g;
        step();
        rel = 2'b00;
        chk("job_released_gnt", 32'(gnt), 32'd0);
        chk("job_released_busy", 32'(arb_busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        load_done = 2'b00;
        rel       = 2'b00;
        mult_done = 1'b0;
        mult_busy = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_owner", 32'(owner_idx), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_jobs", 32'(jobs_completed), 32'd0);
        chk("rst_mult_rst", 32'(mult_rst), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_job_done", 32'(job_done), 32'd0);
        chk("rst_job_err", 32'(job_err), 32'd0);
        rst = 1'b0;
        step();

        // Single requester with stray inputs during DRAIN
        req = 2'b01;
        step();
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_busy", 32'(arb_busy), 32'd1);
        step();
        chk("t1_hold_load", 32'(gnt), 32'd1);
        chk("t1_no_rst_yet", 32'(mult_rst), 32'd0);
        load_done = 2'b01;
        step();
        load_done = 2'b00;
        chk("t1_mult_rst", 32'(mult_rst), 32'd1);
        step();
        chk("t1_mult_start", 32'(mult_start), 32'd1);
        chk("t1_rst_low", 32'(mult_rst), 32'd0);
        mult_busy = 1'b1;
        step();
        chk("t1_start_low", 32'(mult_start), 32'd0);
        step();
        step();
        chk("t1_wait_no_done", 32'(job_done), 32'd0);
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        mult_busy = 1'b0;
        exp_jobs++;
        chk("t1_job_done", 32'(job_done), 32'd1);
        chk("t1_jobs", 32'(jobs_completed), 32'(exp_jobs));
        step();
        chk("t1_done_pulse", 32'(job_done), 32'd0);
        chk("t1_drain_gnt", 32'(gnt), 32'd1);
        mult_done = 1'b1;
        rel       = 2'b10;
        step();
        mult_done = 1'b0;
        rel       = 2'b00;
        step();
        chk("stray_gnt", 32'(gnt), 32'd1);
        chk("stray_jobs", 32'(jobs_completed), 32'(exp_jobs));
        chk("stray_job_done", 32'(job_done), 32'd0);
        chk("stray_busy", 32'(arb_busy), 32'd1);
        rel = 2'b01;
        req = 2'b00;
        step();
        rel = 2'b00;
        chk("t1_release_gnt", 32'(gnt), 32'd0);
        chk("t1_release_busy", 32'(arb_busy), 32'd0);

        // Fairness: last owner was 0, so the rotation begins at requester 1
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_job((k % 2 == 0) ? 2'b10 : 2'b01);
        end
        req = 2'b00;
        step();

        // Abort in LOAD with a coincident load_done
        req = 2'b10;
        step();
        chk("ab_gnt", 32'(gnt), 32'd2);
        req       = 2'b00;
        load_done = 2'b10;
        step();
        load_done = 2'b00;
        chk("ab_gnt_clear", 32'(gnt), 32'd0);
        chk("ab_no_rst", 32'(mult_rst), 32'd0);
        chk("ab_idle", 32'(arb_busy), 32'd0);
        step();
        chk("ab_no_rst2", 32'(mult_rst), 32'd0);
        chk("ab_no_start", 32'(mult_start), 32'd0);
        req = 2'b11;
        step();
        chk("ab_next_gnt", 32'(gnt), 32'd1);

        // Reset while in WAIT
        load_done = 2'b01;
        step();
        load_done = 2'b00;
        step();
        mult_busy = 1'b1;
        step();
        step();
        chk("mid_wait_busy", 32'(arb_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        exp_jobs = 0;
        chk("mr_gnt", 32'(gnt), 32'd0);
        chk("mr_busy", 32'(arb_busy), 32'd0);
        chk("mr_jobs", 32'(jobs_completed), 32'd0);
        step();
        req       = 2'b00;
        mult_busy = 1'b0;
        rst       = 1'b0;
        step();
        chk("mr_idle_gnt", 32'(gnt), 32'd0);
        req = 2'b01;
        run_job(2'b01);
        req = 2'b00;
        step();

        // Watchdog behaviour in WAIT
        req = 2'b01;
        step();
        chk("wd_gnt", 32'(gnt), 32'd1);
        load_done = 2'b01;
        step();
        load_done = 2'b00;
        step();
        mult_busy = 1'b1;
        step();
`ifdef FP2_ARB_TIMEOUT_EN
        repeat (15) step();
        chk("wd_before_err", 32'(job_err), 32'd0);
        chk("wd_before_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        step();
        mult_busy = 1'b0;
        chk("wd_job_err", 32'(job_err), 32'd1);
        chk("wd_mult_rst", 32'(mult_rst), 32'd1);
        chk("wd_gnt_clear", 32'(gnt), 32'd0);
        chk("wd_idle", 32'(arb_busy), 32'd0);
        chk("wd_jobs", 32'(jobs_completed), 32'(exp_jobs));
        step();
        chk("wd_err_pulse", 32'(job_err), 32'd0);
        chk("wd_rst_pulse", 32'(mult_rst), 32'd0);
`else
        repeat (20) step();
        chk("nowd_job_err", 32'(job_err), 32'd0);
        chk("nowd_gnt", 32'(gnt), 32'd1);
        chk("nowd_busy", 32'(arb_busy), 32'd1);
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        mult_busy = 1'b0;
        exp_jobs++;
        chk("nowd_job_done", 32'(job_done), 32'd1);
        chk("nowd_jobs", 32'(jobs_completed), 32'(exp_jobs));
        rel = 2'b01;
        req = 2'b00;
        step();
        rel = 2'b00;
        chk("nowd_release", 32'(gnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule
